// File: rtl/icache_arb_pkg.sv
// Shared types and helpers for the instruction-cache refill arbiter.
// Optional stats ports in the top are enabled with ICACHE_ARB_STATS_EN.
package icache_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GRANT = 2'd3
  } arb_state_t;

  localparam int MEM_LATENCY_DEF = 1;
  localparam int LAT_CNT_W_DEF   = $clog2(MEM_LATENCY_DEF + 1);

  function automatic int lat_cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

  function automatic int next_rr(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/icache_refill_arbiter_picker.sv
// Round-robin priority picker: first set request at or above ptr,
// wrapping modulo N_REQ.
module rr_priority_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     any_valid
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (!any_valid && req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_refill_arbiter.sv
// Round-robin refill arbiter sharing one instruction-memory read port.
// Define ICACHE_ARB_STATS_EN to add saturating grant/coalesce counters.
module icache_refill_arbiter
  import icache_arb_pkg::*;
#(
  parameter int N_REQ            = 4,
  parameter int BLOCK_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH       = 64,
  parameter int MEM_LATENCY      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ*BLOCK_ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]                  req_ready,
  output logic                              bcast_valid,
  output logic [BLOCK_ADDR_WIDTH-1:0]       bcast_addr,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              mem_rd_en,
  output logic [BLOCK_ADDR_WIDTH-1:0]       mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]             mem_rd_data
`ifdef ICACHE_ARB_STATS_EN
  ,
  output logic [31:0]                       stat_grants,
  output logic [31:0]                       stat_coalesced
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = BLOCK_ADDR_WIDTH;
  localparam int CW = lat_cnt_w(MEM_LATENCY);

  arb_state_t    state;
  logic [BW-1:0] grant_addr;
  logic [IW-1:0] winner_q;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] cnt;
  logic [IW-1:0] pick;
  logic          any_valid;
  logic [BW-1:0] addr_arr [N_REQ];

  rr_priority_picker #(.N_REQ(N_REQ)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .winner    (pick),
    .any_valid (any_valid)
  );

  assign mem_rd_en   = (state == S_ISSUE);
  assign mem_rd_addr = mem_rd_en ? grant_addr : '0;
  assign bcast_valid = (state == S_GRANT);
  assign bcast_addr  = bcast_valid ? grant_addr : '0;

  // Every requester on the broadcast block is served by the same read.
  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    assign addr_arr[i]  = req_addr[i*BW +: BW];
    assign req_ready[i] = bcast_valid && req_valid[i]
                       && (addr_arr[i] == grant_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant_addr <= '0;
      winner_q   <= '0;
      rr_ptr     <= '0;
      cnt        <= '0;
      data_out   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_valid) begin
            grant_addr <= addr_arr[pick];
            winner_q   <= pick;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= CW'(MEM_LATENCY - 1);
          state <= (MEM_LATENCY == 1) ? S_GRANT : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1))
            state <= S_GRANT;
        end
        S_GRANT: begin
          data_out <= mem_rd_data;
          rr_ptr   <= IW'(next_rr(int'(winner_q), N_REQ));
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ICACHE_ARB_STATS_EN
  logic [31:0] n_extra;
  logic [32:0] co_sum;

  // A withdrawn winner makes every ready bit an extra one.
  assign n_extra = 32'($countones(req_ready))
                 - {31'd0, req_ready[winner_q]};
  assign co_sum  = {1'b0, stat_coalesced} + {1'b0, n_extra};

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants    <= '0;
      stat_coalesced <= '0;
    end else if (bcast_valid) begin
      if (stat_grants != '1)
        stat_grants <= stat_grants + 32'd1;
      stat_coalesced <= co_sum[32] ? '1 : co_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_icache_refill_arbiter.sv
// Scoreboard bench for icache_refill_arbiter at MEM_LATENCY 1 and 3.
// Stimulus queues expected broadcasts; monitors pop and compare them.
module tb_icache_refill_arbiter;

  typedef struct packed {
    logic [3:0]  rdy;
    logic [11:0] addr;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic        rst_a, rst_b;
  logic [3:0]  rv_a, rv_b, rr_a, rr_b;
  logic [47:0] ra_a, ra_b;
  logic        bv_a, bv_b, me_a, me_b;
  logic [11:0] ba_a, ba_b, ma_a, ma_b;
  logic [63:0] do_a, do_b, md_a, md_b;
`ifdef ICACHE_ARB_STATS_EN
  logic [31:0] sg_a, sc_a, sg_b, sc_b;
`endif

  exp_t qa[$];
  exp_t qb[$];
  int   gca[$];
  int   gcb[$];

  function automatic logic [63:0] mem_f(input logic [11:0] a);
    if (a == 12'h123) return 64'hDEADBEEF_CAFEF00D;
    return {20'hC0FFE, a, 20'hBEEF0, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  icache_refill_arbiter #(.MEM_LATENCY(1)) dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .req_valid   (rv_a),
    .req_addr    (ra_a),
    .req_ready   (rr_a),
    .bcast_valid (bv_a),
    .bcast_addr  (ba_a),
    .data_out    (do_a),
    .mem_rd_en   (me_a),
    .mem_rd_addr (ma_a),
    .mem_rd_data (md_a)
`ifdef ICACHE_ARB_STATS_EN
    ,
    .stat_grants    (sg_a),
    .stat_coalesced (sc_a)
`endif
  );

  icache_refill_arbiter #(.MEM_LATENCY(3)) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .req_valid   (rv_b),
    .req_addr    (ra_b),
    .req_ready   (rr_b),
    .bcast_valid (bv_b),
    .bcast_addr  (ba_b),
    .data_out    (do_b),
    .mem_rd_en   (me_b),
    .mem_rd_addr (ma_b),
    .mem_rd_data (md_b)
`ifdef ICACHE_ARB_STATS_EN
    ,
    .stat_grants    (sg_b),
    .stat_coalesced (sc_b)
`endif
  );

  // Memory models: data appears MEM_LATENCY cycles after the strobe.
  logic [11:0] pa = '0;
  logic [11:0] pb [3];
  always @(posedge clk) if (me_a) pa <= ma_a;
  always @(posedge clk) begin
    pb[2] <= pb[1];
    pb[1] <= pb[0];
    pb[0] <= ma_b;
  end
  assign md_a = mem_f(pa);
  assign md_b = mem_f(pb[2]);

  logic        dchk_a = 0, dchk_b = 0;
  logic [63:0] dexp_a, dexp_b;

  always @(negedge clk) begin
    exp_t e;
    if (dchk_a) begin
      chk("data_a", do_a, dexp_a);
      dchk_a = 0;
    end
    if (bv_a) begin
      if (qa.size() == 0) begin
        chk("unexp_bcast_a", {52'd0, ba_a}, 64'hFFFF);
      end else begin
        e = qa.pop_front();
        chk("ready_a", {60'd0, rr_a}, {60'd0, e.rdy});
        chk("baddr_a", {52'd0, ba_a}, {52'd0, e.addr});
        dexp_a = e.data;
        dchk_a = 1;
        gca.push_back(cyc);
      end
    end else if (rr_a != 4'd0) begin
      chk("ready_nobcast_a", {60'd0, rr_a}, 64'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (dchk_b) begin
      chk("data_b", do_b, dexp_b);
      dchk_b = 0;
    end
    if (bv_b) begin
      if (qb.size() == 0) begin
        chk("unexp_bcast_b", {52'd0, ba_b}, 64'hFFFF);
      end else begin
        e = qb.pop_front();
        chk("ready_b", {60'd0, rr_b}, {60'd0, e.rdy});
        chk("baddr_b", {52'd0, ba_b}, {52'd0, e.addr});
        dexp_b = e.data;
        dchk_b = 1;
        gcb.push_back(cyc);
      end
    end else if (rr_b != 4'd0) begin
      chk("ready_nobcast_b", {60'd0, rr_b}, 64'd0);
    end
  end

  // One cycle; requesters drop valid after seeing their ready.
  task automatic cyc_a();
    logic [3:0] s;
    @(negedge clk);
    s = rr_a;
    @(posedge clk);
    #1;
    rv_a = rv_a & ~s;
  endtask

  task automatic cyc_b();
    logic [3:0] s;
    @(negedge clk);
    s = rr_b;
    @(posedge clk);
    #1;
    rv_b = rv_b & ~s;
  endtask

  initial begin
    int t0;
    int n;
    rst_a = 1; rst_b = 1;
    rv_a = 0; rv_b = 0;
    ra_a = 0; ra_b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_a", {60'd0, rr_a}, 64'd0);
    chk("rst_bcast_a", {63'd0, bv_a}, 64'd0);
    chk("rst_baddr_a", {52'd0, ba_a}, 64'd0);
    chk("rst_data_a", do_a, 64'd0);
    chk("rst_rden_a", {63'd0, me_a}, 64'd0);
    chk("rst_rdaddr_a", {52'd0, ma_a}, 64'd0);
    rst_a = 0; rst_b = 0;
    cyc_a();

    // single request
    ra_a[12 +: 12] = 12'h123;
    rv_a = 4'b0010;
    t0 = cyc;
    gca.delete();
    qa.push_back(exp_t'{4'b0010, 12'h123, 64'hDEADBEEF_CAFEF00D});
    cyc_a();
    chk("t1_rden", {63'd0, me_a}, 64'd1);
    chk("t1_rdaddr", {52'd0, ma_a}, 64'h123);
    repeat (4) cyc_a();
    chk("t1_ngrant", gca.size(), 1);
    if (gca.size() > 0) chk("t1_gcyc", gca[0], t0 + 2);

    // round robin from a fresh pointer
    rst_a = 1;
    cyc_a();
    rst_a = 0;
    gca.delete();
    for (int i = 0; i < 4; i++) ra_a[i*12 +: 12] = 12'(12'h100 + i);
    for (int k = 0; k < 5; k++)
      qa.push_back(exp_t'{4'(1 << (k % 4)), 12'(12'h100 + k % 4),
                          mem_f(12'(12'h100 + k % 4))});
    rv_a = 4'hF;
    t0 = cyc;
    for (int k = 1; k <= 15; k++) begin
      cyc_a();
      rv_a = (k < 15) ? 4'hF : 4'h0;
    end
    chk("rr_ngrant", gca.size(), 5);
    for (int i = 0; i < gca.size(); i++)
      chk($sformatf("rr_gcyc%0d", i), gca[i], t0 + 2 + 3 * i);

    // coalescing, pointer now 1 so req 2 wins
    gca.delete();
    ra_a[0 +: 12]  = 12'h040;
    ra_a[24 +: 12] = 12'h040;
    rv_a = 4'b0101;
    t0 = cyc;
    qa.push_back(exp_t'{4'b0101, 12'h040, mem_f(12'h040)});
    n = 0;
    for (int k = 0; k < 5; k++) begin
      cyc_a();
      n += int'(me_a);
    end
    chk("co_nrd", n, 1);
    chk("co_ngrant", gca.size(), 1);
    if (gca.size() > 0) chk("co_gcyc", gca[0], t0 + 2);

    // withdrawn during issue
    gca.delete();
    ra_a[12 +: 12] = 12'h2AA;
    rv_a = 4'b0010;
    t0 = cyc;
    qa.push_back(exp_t'{4'b0000, 12'h2AA, mem_f(12'h2AA)});
    cyc_a();
    rv_a = 4'b0000;
    repeat (4) cyc_a();
    chk("wd_ngrant", gca.size(), 1);
    if (gca.size() > 0) chk("wd_gcyc", gca[0], t0 + 2);

    // late arrivals: matching one joins, other waits
    gca.delete();
    ra_a[0 +: 12]  = 12'h055;
    ra_a[12 +: 12] = 12'h055;
    ra_a[24 +: 12] = 12'h066;
    rv_a = 4'b0001;
    t0 = cyc;
    qa.push_back(exp_t'{4'b0011, 12'h055, mem_f(12'h055)});
    qa.push_back(exp_t'{4'b0100, 12'h066, mem_f(12'h066)});
    cyc_a();
    rv_a = 4'b0111;
    repeat (7) cyc_a();
    chk("late_ngrant", gca.size(), 2);
    if (gca.size() > 1) begin
      chk("late_gcyc0", gca[0], t0 + 2);
      chk("late_gcyc1", gca[1], t0 + 5);
    end

    // latency 3, single request
    gcb.delete();
    ra_b[24 +: 12] = 12'h3C5;
    rv_b = 4'b0100;
    t0 = cyc;
    qb.push_back(exp_t'{4'b0100, 12'h3C5, mem_f(12'h3C5)});
    cyc_b();
    chk("l3_rden", {63'd0, me_b}, 64'd1);
    chk("l3_rdaddr", {52'd0, ma_b}, 64'h3C5);
    cyc_b();
    chk("l3_rden_wait", {63'd0, me_b}, 64'd0);
    repeat (3) cyc_b();
    chk("l3_ngrant", gcb.size(), 1);
    if (gcb.size() > 0) chk("l3_gcyc", gcb[0], t0 + 4);
    cyc_b();
    chk("l3_data_hold", do_b, mem_f(12'h3C5));

    // reset during wait, pointer was 3 before it
    gcb.delete();
    ra_b[24 +: 12] = 12'h0F0;
    rv_b = 4'b0100;
    cyc_b();
    cyc_b();
    rst_b = 1;
    rv_b = 4'b0000;
    cyc_b();
    chk("ab_ready", {60'd0, rr_b}, 64'd0);
    chk("ab_bcast", {63'd0, bv_b}, 64'd0);
    chk("ab_baddr", {52'd0, ba_b}, 64'd0);
    chk("ab_rden", {63'd0, me_b}, 64'd0);
    chk("ab_rdaddr", {52'd0, ma_b}, 64'd0);
    chk("ab_data", do_b, 64'd0);
    rst_b = 0;
    cyc_b();
    ra_b[0 +: 12]  = 12'h011;
    ra_b[36 +: 12] = 12'h033;
    rv_b = 4'b1001;
    t0 = cyc;
    qb.push_back(exp_t'{4'b0001, 12'h011, mem_f(12'h011)});
    qb.push_back(exp_t'{4'b1000, 12'h033, mem_f(12'h033)});
    repeat (14) cyc_b();
    chk("ab_ngrant", gcb.size(), 2);
    if (gcb.size() > 1) begin
      chk("ab_gcyc0", gcb[0], t0 + 4);
      chk("ab_gcyc1", gcb[1], t0 + 9);
    end

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
